// File: rtl/i2s_sample_feeder.sv
// i2s_sample_feeder: stereo pair FIFO feeding the I2S transmitter data words.
// Ports: clk_i2s/reset (async, active-high); s_data_l/s_data_r/s_valid/s_ready
//   push side; lrclk from the transmitter; tx_data_l/tx_data_r registered
//   words; level (pairs stored); underrun (1-cycle pulse on empty frame pop).
// Optional macro I2S_FEEDER_REPEAT_EN: repeat the last pair on underrun
//   instead of muting.
module i2s_sample_feeder #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i2s,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     s_data_l,
    input  logic [DATA_W-1:0]     s_data_r,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  lrclk,
    output logic [DATA_W-1:0]     tx_data_l,
    output logic [DATA_W-1:0]     tx_data_r,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [2*DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_lrclk_q;
    logic                  r_ready;
    logic [DATA_W-1:0]     r_tx_l;
    logic [DATA_W-1:0]     r_tx_r;
    logic                  r_underrun;

    logic                  w_push;
    logic                  w_pop_evt;
    logic                  w_pop;
    logic [DEPTH_LOG2:0]   w_level_nxt;
    logic [2*DATA_W-1:0]   w_head;

    assign w_push    = s_valid && r_ready;
    // Rising lrclk starts the right half; the transmitter already latched
    // both words at the preceding fall, so updating here is glitch-free.
    assign w_pop_evt = lrclk && !r_lrclk_q;
    assign w_pop     = w_pop_evt && (r_level != '0);
    assign w_head    = r_mem[r_rptr];

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage has no reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk_i2s) begin
        if (w_push) begin
            r_mem[r_wptr] <= {s_data_l, s_data_r};
        end
    end

    always_ff @(posedge clk_i2s or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_lrclk_q  <= 1'b0;
            r_ready    <= 1'b0;
            r_tx_l     <= '0;
            r_tx_r     <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_lrclk_q  <= lrclk;
            r_level    <= w_level_nxt;
            // Registered copy of (level != max) so ready stays low in reset.
            r_ready    <= (w_level_nxt != LVL_MAX);
            r_underrun <= w_pop_evt && (r_level == '0);
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_tx_l <= w_head[2*DATA_W-1:DATA_W];
                r_tx_r <= w_head[DATA_W-1:0];
            end else if (w_pop_evt) begin
`ifdef I2S_FEEDER_REPEAT_EN
                r_tx_l <= r_tx_l;
                r_tx_r <= r_tx_r;
`else
                r_tx_l <= '0;
                r_tx_r <= '0;
`endif
            end
        end
    end

    assign s_ready   = r_ready;
    assign tx_data_l = r_tx_l;
    assign tx_data_r = r_tx_r;
    assign level     = r_level;
    assign underrun  = r_underrun;

endmodule

// File: doc/i2s_sample_feeder.md
Name: i2s_sample_feeder

Overview:
Stereo sample buffer directly upstream of the i2s transmitter; drives its tx_data_l / tx_data_r inputs.
- Accepts left/right sample pairs from the audio source over a valid/ready handshake into a FIFO.
- Presents exactly one new pair per I2S frame, timed from the transmitter's tx_lrclk output.
- Reports FIFO level and underruns so the source can pace itself.

Parameters:
DATA_W, 16, sample width per channel; matches the transmitter's tx_data_l/tx_data_r width.
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 stereo pairs (default 16).

Ports:
clk_i2s  in  1  12.288 MHz I2S clock; same clock as the transmitter.
reset  in  1  asynchronous, active-high reset.
s_data_l  in  DATA_W  left sample of the incoming pair.
s_data_r  in  DATA_W  right sample of the incoming pair.
s_valid  in  1  incoming pair valid.
s_ready  out  1  FIFO can accept a pair.
lrclk  in  1  tx_lrclk from the transmitter (clk_i2s/256; low = left channel).
tx_data_l  out  DATA_W  left word to the transmitter.
tx_data_r  out  DATA_W  right word to the transmitter.
level  out  DEPTH_LOG2+1  number of pairs stored, 0..2**DEPTH_LOG2.
underrun  out  1  one-cycle pulse when a frame pop finds the FIFO empty.

Behaviour:
- Reset (asynchronous, active-high): all outputs, pointers, level and lrclk_q are 0. s_ready=0 while reset is high; s_ready=1 on the first clk_i2s edge after release.
- Push: a pair is written when s_valid && s_ready at a clk_i2s edge.
  - s_ready = (level != 2**DEPTH_LOG2), computed from registered level.
  - A pop in the same cycle does not make a full FIFO ready.
- Frame strobe:
  - lrclk is in the clk_i2s domain; it is registered once into lrclk_q with no synchroniser.
  - pop_evt = lrclk && !lrclk_q, i.e. the rising edge that starts the right half-frame.
  - pop_evt occurs once every 256 cycles.
- Transmitter contract: the transmitter latches both words at its frame start (lrclk falling). Updating the words at the lrclk rise is therefore glitch-free for the frame in flight.
- Pop on pop_evt with level > 0:
  - tx_data_l/tx_data_r take the head pair on the same edge that registers lrclk_q=1.
  - The read pointer advances and level decrements on that edge.
- Pop on pop_evt with level == 0 (underrun):
  - underrun=1 for exactly that one cycle.
  - Outputs follow the Optional Feature rule.
  - The read pointer does not move.
- Outputs are registered and hold their value between pop_evts.
- Simultaneous push and pop:
  - With 0 < level < max: both occur and level is unchanged.
  - With level==0: the push is stored, the pop is an underrun, and level becomes 1. The fresh pair is not bypassed to the outputs.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. level is a separate counter, so full and empty are unambiguous.
- The FIFO stores {s_data_l, s_data_r}, 2*DATA_W bits per entry. Inferred RAM or registers are both acceptable; a read is visible one edge after pop_evt at most, per the timing above.
- Reset asserted mid-operation discards all buffered pairs immediately; outputs go to 0 asynchronously.

Optional Feature:
Macro I2S_FEEDER_REPEAT_EN.
- Defined: on underrun, tx_data_l/tx_data_r hold the last popped pair (repeat the sample).
- Undefined: on underrun, tx_data_l/tx_data_r are set to 0 (mute) on the pop_evt edge.
- The underrun pulse behaves identically in both builds.

Test Plan:
1. Release reset, push (16'hdead, 16'hbeef) at level 0, lrclk low → level=1; at the first lrclk rise tx_data_l=16'hdead, tx_data_r=16'hbeef, and level=0 on the same edge.
2. Push 17 pairs back-to-back with lrclk held low → s_ready falls after the 16th accept, level=16, 17th pair not written; first pop returns pair #1.
3. Empty FIFO with outputs 16'h1234/16'h5678, then an lrclk rise → underrun high for exactly 1 cycle; outputs 0/0 without the macro, 16'h1234/16'h5678 with I2S_FEEDER_REPEAT_EN.
4. Level=3 with push coincident with pop_evt → level stays 3, output = old head, new pair stored at tail.
5. Level=5, assert reset between edges mid-stream → outputs 0 and level 0 immediately, s_ready 0 during reset, 1 one edge after release; the next pop is an underrun.
6. Free-running transmitter (lrclk = clk_i2s/256) with 4 pairs preloaded → outputs change exactly every 256 cycles; 4 pops, then an underrun on the 5th rise.
